// File: rtl/mlaccel_spi_slave.sv
// SPI mode-3 slave front end: oversamples the SPI pins in the system clock domain,
// deserializes MOSI into rx byte strobes and serializes decoder bytes onto MISO.
`timescale 1ns/1ps
module mlaccel_spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter int          GLITCH_LEN  = 2,
  parameter logic [7:0]  TX_IDLE     = 8'h00
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       spi_csb,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       xfer_start,
  output logic       xfer_end,
  output logic       xfer_abort,
  output logic       rx_valid,
  output logic       rx_first,
  output logic [7:0] rx_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  localparam int GCW = (GLITCH_LEN < 2) ? 1 : $clog2(GLITCH_LEN + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  logic           filt_q, filt_d;
  logic           filt_prev_q, filt_prev_d;
  logic [GCW-1:0] gcnt_q, gcnt_d;

  logic [0:0] state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       first_q, first_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       xfer_start_q, xfer_start_d;
  logic       xfer_end_q, xfer_end_d;
  logic       xfer_abort_q, xfer_abort_d;
  logic [6:0] tx_rem_q, tx_rem_d;
  logic       miso_q, miso_d;
  logic       tx_ready_d;

  logic csb_s, sclk_s, mosi_s;
  logic rise_w, fall_w;

  assign csb_s  = csb_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edges come from the filtered clock only, so a rejected glitch never shifts a bit.
  assign rise_w = filt_q & ~filt_prev_q;
  assign fall_w = ~filt_q & filt_prev_q;

  always_comb begin
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};

    filt_d      = filt_q;
    filt_prev_d = filt_q;
    gcnt_d      = '0;
    if (sclk_s != filt_q) begin
      if (gcnt_q == GCW'(GLITCH_LEN - 1)) begin
        filt_d = sclk_s;
      end else begin
        gcnt_d = gcnt_q + 1'b1;
      end
    end

    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    first_d      = first_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_first_d   = rx_first_q;
    rx_valid_d   = 1'b0;
    xfer_start_d = 1'b0;
    xfer_end_d   = 1'b0;
    xfer_abort_d = 1'b0;
    tx_rem_d     = tx_rem_q;
    miso_d       = miso_q;
    tx_ready_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!csb_s) begin
          state_d      = ST_ACTIVE;
          xfer_start_d = 1'b1;
          bitcnt_d     = 3'd0;
          first_d      = 1'b1;
        end
      end
      default: begin
        // Deselect has priority over any clock edge seen in the same cycle.
        if (csb_s) begin
          state_d      = ST_IDLE;
          xfer_end_d   = 1'b1;
          xfer_abort_d = (bitcnt_q != 3'd0);
          bitcnt_d     = 3'd0;
        end else if (rise_w) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bitcnt_d   = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            rx_valid_d = 1'b1;
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_first_d = first_q;
            first_d    = 1'b0;
          end
        end else if (fall_w) begin
          if (bitcnt_q == 3'd0) begin
            if (tx_valid) begin
              tx_ready_d = 1'b1;
              miso_d     = tx_data[7];
              tx_rem_d   = tx_data[6:0];
            end else begin
              miso_d     = TX_IDLE[7];
              tx_rem_d   = TX_IDLE[6:0];
            end
          end else begin
            miso_d   = tx_rem_q[6];
            tx_rem_d = {tx_rem_q[5:0], 1'b0};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      csb_sync_q   <= '1;
      sclk_sync_q  <= '1;
      mosi_sync_q  <= '0;
      filt_q       <= 1'b1;
      filt_prev_q  <= 1'b1;
      gcnt_q       <= '0;
      state_q      <= ST_IDLE;
      bitcnt_q     <= 3'd0;
      first_q      <= 1'b0;
      rx_shift_q   <= 7'd0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      xfer_start_q <= 1'b0;
      xfer_end_q   <= 1'b0;
      xfer_abort_q <= 1'b0;
      tx_rem_q     <= TX_IDLE[6:0];
      miso_q       <= 1'b0;
    end else begin
      csb_sync_q   <= csb_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      filt_q       <= filt_d;
      filt_prev_q  <= filt_prev_d;
      gcnt_q       <= gcnt_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      first_q      <= first_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      xfer_start_q <= xfer_start_d;
      xfer_end_q   <= xfer_end_d;
      xfer_abort_q <= xfer_abort_d;
      tx_rem_q     <= tx_rem_d;
      miso_q       <= miso_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == ST_ACTIVE);
  assign xfer_start  = xfer_start_q;
  assign xfer_end    = xfer_end_q;
  assign xfer_abort  = xfer_abort_q;
  assign rx_valid    = rx_valid_q;
  assign rx_first    = rx_first_q;
  assign rx_data     = rx_data_q;
  assign tx_ready    = tx_ready_d;

endmodule
